// File: rtl/load_store_unit.sv
// Single-outstanding RISC-V load/store unit in front of a 64-bit doubleword data port.
// Sub-doubleword stores are performed as read-modify-write of the containing doubleword.
module load_store_unit #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic [4:0]            resp_rd,
   output logic [1:0]            resp_err,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_write_data,
   output logic                  dmem_read,
   output logic                  dmem_write,
   input  logic [DATA_WIDTH-1:0] dmem_read_data,
   input  logic                  dmem_ready
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STORE_RD,
      STORE_WR,
      RESP
   } state_t;

   state_t                  state_q;
   logic                    req_ready_q;
   logic                    resp_valid_q;
   logic                    dmem_read_q;
   logic                    dmem_write_q;
   logic [2:0]              funct3_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [4:0]              rd_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [1:0]              err_q;
   logic [CNT_W-1:0]        cnt_q;

   logic                    accept_d;
   logic                    illegal_d;
   logic                    misalign_d;
   logic                    timeout_d;
   logic [DATA_WIDTH-1:0]   load_data_d;
   logic [DATA_WIDTH-1:0]   merge_data_d;

   // Shift the addressed bytes down to bit 0 and extend according to funct3.
   function automatic logic [DATA_WIDTH-1:0] extract_load(
      input logic [DATA_WIDTH-1:0] dw,
      input logic [2:0]            off,
      input logic [2:0]            f3
   );
      logic [DATA_WIDTH-1:0] sh;
      sh = dw >> {off, 3'b000};
      case (f3)
         3'b000:  extract_load = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
         3'b001:  extract_load = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
         3'b010:  extract_load = {{(DATA_WIDTH-32){sh[31]}}, sh[31:0]};
         3'b100:  extract_load = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
         3'b101:  extract_load = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
         3'b110:  extract_load = {{(DATA_WIDTH-32){1'b0}}, sh[31:0]};
         default: extract_load = sh;
      endcase
   endfunction

   // Replace the addressed lanes of the old doubleword with the low bytes of the store data.
   function automatic logic [DATA_WIDTH-1:0] merge_store(
      input logic [DATA_WIDTH-1:0] dw,
      input logic [DATA_WIDTH-1:0] wd,
      input logic [2:0]            off,
      input logic [1:0]            sz
   );
      logic [DATA_WIDTH-1:0] mask;
      case (sz)
         2'b00:   mask = DATA_WIDTH'(8'hFF);
         2'b01:   mask = DATA_WIDTH'(16'hFFFF);
         2'b10:   mask = DATA_WIDTH'(32'hFFFF_FFFF);
         default: mask = '1;
      endcase
      mask = mask << {off, 3'b000};
      merge_store = (dw & ~mask) | ((wd << {off, 3'b000}) & mask);
   endfunction

   assign accept_d  = req_valid && req_ready_q;
   assign illegal_d = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
   assign timeout_d = (cnt_q == TMO_LAST);

   always_comb begin
      misalign_d = 1'b0;
      case (req_funct3[1:0])
         2'b01:   misalign_d = req_addr[0];
         2'b10:   misalign_d = |req_addr[1:0];
         2'b11:   misalign_d = |req_addr[2:0];
         default: misalign_d = 1'b0;
      endcase
   end

   assign load_data_d  = extract_load(dmem_read_data, addr_q[2:0], funct3_q);
   assign merge_data_d = merge_store(dmem_read_data, data_q, addr_q[2:0], funct3_q[1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         dmem_read_q  <= 1'b0;
         dmem_write_q <= 1'b0;
         funct3_q     <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         rd_q         <= '0;
         rdata_q      <= '0;
         err_q        <= ERR_OK;
         cnt_q        <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  funct3_q    <= req_funct3;
                  addr_q      <= req_addr;
                  data_q      <= req_wdata;
                  rd_q        <= req_rd;
                  rdata_q     <= '0;
                  err_q       <= ERR_OK;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b0;
                  // Illegal encodings win over misalignment; neither touches memory.
                  if (illegal_d) begin
                     err_q        <= ERR_ILLEGAL;
                     resp_valid_q <= 1'b1;
                     state_q      <= RESP;
                  end else if (misalign_d) begin
                     err_q        <= ERR_MISALIGN;
                     resp_valid_q <= 1'b1;
                     state_q      <= RESP;
                  end else if (!req_is_store) begin
                     dmem_read_q <= 1'b1;
                     state_q     <= LOAD;
                  end else if (req_funct3[1:0] == 2'b11) begin
                     dmem_write_q <= 1'b1;
                     state_q      <= STORE_WR;
                  end else begin
                     dmem_read_q <= 1'b1;
                     state_q     <= STORE_RD;
                  end
               end
            end
            LOAD: begin
               if (dmem_ready) begin
                  rdata_q      <= load_data_d;
                  dmem_read_q  <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else if (timeout_d) begin
                  err_q        <= ERR_TIMEOUT;
                  dmem_read_q  <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STORE_RD: begin
               if (dmem_ready) begin
                  data_q       <= merge_data_d;
                  cnt_q        <= '0;
                  dmem_read_q  <= 1'b0;
                  dmem_write_q <= 1'b1;
                  state_q      <= STORE_WR;
               end else if (timeout_d) begin
                  err_q        <= ERR_TIMEOUT;
                  dmem_read_q  <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STORE_WR: begin
               if (dmem_ready) begin
                  dmem_write_q <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else if (timeout_d) begin
                  err_q        <= ERR_TIMEOUT;
                  dmem_write_q <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               dmem_read_q  <= 1'b0;
               dmem_write_q <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign req_ready       = req_ready_q;
   assign resp_valid      = resp_valid_q;
   assign resp_rdata      = rdata_q;
   assign resp_rd         = rd_q;
   assign resp_err        = err_q;
   assign dmem_addr       = {addr_q[ADDR_WIDTH-1:3], 3'b000};
   assign dmem_write_data = data_q;
   assign dmem_read       = dmem_read_q;
   assign dmem_write      = dmem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a responding memory model plus a
// response scoreboard fed at request acceptance.
module tb_load_store_unit;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic [1:0]  resp_err;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_write_data;
   logic        dmem_read;
   logic        dmem_write;
   logic [63:0] dmem_read_data;
   logic        dmem_ready;

   load_store_unit #(
      .ADDR_WIDTH     (64),
      .DATA_WIDTH     (64),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_is_store    (req_is_store),
      .req_funct3      (req_funct3),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_rd          (req_rd),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_rd         (resp_rd),
      .resp_err        (resp_err),
      .dmem_addr       (dmem_addr),
      .dmem_write_data (dmem_write_data),
      .dmem_read       (dmem_read),
      .dmem_write      (dmem_write),
      .dmem_read_data  (dmem_read_data),
      .dmem_ready      (dmem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] rdata;
      logic [1:0]  err;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          last_resp_cyc = 0;
   int          resp_count = 0;
   int          rd_hs = 0;
   int          wr_hs = 0;
   int          acc_cycles = 0;
   int          wait_cnt = 0;
   int          ready_delay = 0;
   bit          rw_overlap = 1'b0;
   bit          resp_dmem_rw = 1'b0;
   logic [63:0] last_wr_addr = '0;
   logic [63:0] last_wr_data = '0;
   logic [63:0] mem [16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Little-endian byte-lane model of a load.
   function automatic logic [63:0] model_load(input logic [63:0] dw, input logic [2:0] off,
                                              input logic [2:0] f3);
      int          n = 1 << f3[1:0];
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v[i*8 +: 8] = dw[(off+i)*8 +: 8];
      if (!f3[2] && n < 8 && v[n*8-1]) begin
         for (int i = n*8; i < 64; i++) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [63:0] model_store(input logic [63:0] dw, input logic [63:0] wd,
                                               input logic [2:0] off, input logic [1:0] sz);
      int n = 1 << sz;
      for (int i = 0; i < n; i++) dw[(off+i)*8 +: 8] = wd[i*8 +: 8];
      return dw;
   endfunction

   // Memory port model: ready arrives ready_delay cycles after an access begins.
   always @(negedge clk) begin
      dmem_ready = 1'b0;
      if (dmem_read && dmem_write) rw_overlap = 1'b1;
      if (dmem_read || dmem_write) begin
         acc_cycles++;
         if (wait_cnt == ready_delay) begin
            dmem_ready = 1'b1;
            wait_cnt = 0;
            if (dmem_read) begin
               dmem_read_data = mem[dmem_addr[6:3]];
               rd_hs++;
            end else begin
               mem[dmem_addr[6:3]] = dmem_write_data;
               last_wr_addr = dmem_addr;
               last_wr_data = dmem_write_data;
               wr_hs++;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (resp_valid) begin
         resp_count++;
         last_resp_cyc = cyc;
         resp_dmem_rw = dmem_read | dmem_write;
         chk_i("resp_expected", int'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("resp_rd", 64'(resp_rd), 64'(e.rd));
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 64'(resp_err), 64'(e.err));
         end
      end
   end

   task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] exp_rdata, input logic [1:0] exp_err, input bit hold);
      int k = 0;
      req_valid    = 1'b1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wd;
      req_rd       = rd;
      while (req_ready !== 1'b1 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk_i("accept_bound", int'(k < 200), 1);
      sb_q.push_back('{rd, exp_rdata, exp_err});
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int k = 0;
      while (sb_q.size() != 0 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk_i(tag, sb_q.size(), 0);
   endtask

   logic [2:0]  ld_f3  [7] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b110, 3'b011, 3'b100};
   logic [63:0] ld_adr [7] = '{64'h27, 64'h20, 64'h26, 64'h24, 64'h24, 64'h20, 64'h14};
   int          ld_dly [7] = '{0, 1, 3, 0, 2, 1, 0};

   logic        er_st  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [2:0]  er_f3  [7] = '{3'b010, 3'b010, 3'b001, 3'b011, 3'b111, 3'b100, 3'b111};
   logic [63:0] er_adr [7] = '{64'h06, 64'h02, 64'h01, 64'h04, 64'h08, 64'h10, 64'h03};
   logic [1:0]  er_exp [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};

   initial begin
      int rd0, wr0, acc0, rc0;
      logic [63:0] old;
      #100000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rd0, wr0, acc0, rc0;
      logic [63:0] old;
      rst = 1'b1;
      req_valid = 1'b0;
      req_is_store = 1'b0;
      req_funct3 = '0;
      req_addr = '0;
      req_wdata = '0;
      req_rd = '0;
      dmem_ready = 1'b0;
      dmem_read_data = '0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_b("rst_req_ready", req_ready, 1'b1);
      chk_b("rst_resp_valid", resp_valid, 1'b0);
      chk_b("rst_dmem_read", dmem_read, 1'b0);
      chk_b("rst_dmem_write", dmem_write, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 64'h0);
      chk("rst_resp_err", 64'(resp_err), 64'h0);
      chk("rst_resp_rd", 64'(resp_rd), 64'h0);
      chk("rst_dmem_addr", dmem_addr, 64'h0);
      chk("rst_dmem_wdata", dmem_write_data, 64'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Signed byte load with a two-cycle memory wait.
      mem[2] = 64'h0000_0000_8000_0000;
      ready_delay = 2;
      rd0 = rd_hs;
      wr0 = wr_hs;
      issue(1'b0, 3'b000, 64'h13, 64'h0, 5'd1, 64'hFFFF_FFFF_FFFF_FF80, 2'b00, 1'b0);
      wait_resp("lb_done");
      chk_i("lb_latency", last_resp_cyc - acc_cyc, 3);
      chk_i("lb_rd_hs", rd_hs - rd0, 1);
      chk_i("lb_wr_hs", wr_hs - wr0, 0);

      mem[2] = 64'h0000_0080_0000_0000;
      mem[4] = 64'h8001_7FFF_1234_ABCD;
      for (int i = 0; i < 7; i++) begin
         ready_delay = ld_dly[i];
         issue(1'b0, ld_f3[i], ld_adr[i], 64'h0, 5'(i + 2),
               model_load(mem[ld_adr[i][6:3]], ld_adr[i][2:0], ld_f3[i]), 2'b00, 1'b0);
         wait_resp($sformatf("load%0d_done", i));
         chk_i($sformatf("load%0d_latency", i), last_resp_cyc - acc_cyc, ld_dly[i] + 1);
      end

      // Halfword store: read-modify-write of the containing doubleword.
      mem[1] = 64'h1111_2222_3333_4444;
      ready_delay = 1;
      rd0 = rd_hs;
      wr0 = wr_hs;
      issue(1'b1, 3'b001, 64'h0A, 64'hBEEF, 5'd12, 64'h0, 2'b00, 1'b0);
      wait_resp("sh_done");
      chk("sh_wr_addr", last_wr_addr, 64'h08);
      chk("sh_wr_data", last_wr_data, 64'h1111_2222_BEEF_4444);
      chk_i("sh_rd_hs", rd_hs - rd0, 1);
      chk_i("sh_wr_hs", wr_hs - wr0, 1);

      old = mem[1];
      issue(1'b1, 3'b000, 64'h0F, 64'hFFFF_FFAB, 5'd13, 64'h0, 2'b00, 1'b0);
      wait_resp("sb_done");
      chk("sb_wr_data", last_wr_data, model_store(old, 64'hFFFF_FFAB, 3'd7, 2'd0));

      old = mem[1];
      ready_delay = 0;
      issue(1'b1, 3'b010, 64'h0C, 64'h9999_55AA_7788, 5'd14, 64'h0, 2'b00, 1'b0);
      wait_resp("sw_done");
      chk("sw_wr_data", last_wr_data, model_store(old, 64'h9999_55AA_7788, 3'd4, 2'd2));

      rd0 = rd_hs;
      wr0 = wr_hs;
      issue(1'b1, 3'b011, 64'h18, 64'hDEAD_BEEF_0123_4567, 5'd15, 64'h0, 2'b00, 1'b0);
      wait_resp("sd_done");
      chk("sd_wr_addr", last_wr_addr, 64'h18);
      chk("sd_wr_data", last_wr_data, 64'hDEAD_BEEF_0123_4567);
      chk_i("sd_rd_hs", rd_hs - rd0, 0);
      chk_i("sd_wr_hs", wr_hs - wr0, 1);

      // Misaligned and illegal requests must not touch memory.
      for (int i = 0; i < 7; i++) begin
         acc0 = acc_cycles;
         issue(er_st[i], er_f3[i], er_adr[i], 64'h55, 5'(i + 16), 64'h0, er_exp[i], 1'b0);
         wait_resp($sformatf("err%0d_done", i));
         chk_i($sformatf("err%0d_fast", i), int'((last_resp_cyc - acc_cyc) <= 2), 1);
         chk_i($sformatf("err%0d_no_access", i), acc_cycles - acc0, 0);
      end

      // Memory never answers: load and store-read time out.
      ready_delay = 255;
      issue(1'b0, 3'b011, 64'h20, 64'h0, 5'd24, 64'h0, 2'b10, 1'b0);
      wait_resp("ld_tmo_done");
      chk_i("ld_tmo_latency", last_resp_cyc - acc_cyc, TMO);
      chk_b("ld_tmo_rw_in_resp", resp_dmem_rw, 1'b0);
      wr0 = wr_hs;
      issue(1'b1, 3'b010, 64'h20, 64'h1234, 5'd25, 64'h0, 2'b10, 1'b0);
      wait_resp("sw_tmo_done");
      chk_i("sw_tmo_latency", last_resp_cyc - acc_cyc, TMO);
      chk_i("sw_tmo_wr_hs", wr_hs - wr0, 0);

      // SD with req_valid held: the next request waits until after the response.
      ready_delay = 2;
      issue(1'b1, 3'b011, 64'h18, 64'h0BAD_F00D_0000_0001, 5'd26, 64'h0, 2'b00, 1'b1);
      issue(1'b0, 3'b011, 64'h20, 64'h0, 5'd27, model_load(mem[4], 3'd0, 3'b011), 2'b00, 1'b0);
      chk_i("b2b_accept_after_resp", int'((acc_cyc - last_resp_cyc) >= 2), 1);
      wait_resp("b2b_done");

      // Reset in the middle of a store write abandons it silently.
      ready_delay = 255;
      rc0 = resp_count;
      issue(1'b1, 3'b011, 64'h28, 64'h1234, 5'd28, 64'h0, 2'b00, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      chk_b("mid_rst_pre_write", dmem_write, 1'b1);
      rst = 1'b1;
      #1;
      chk_b("mid_rst_dmem_write", dmem_write, 1'b0);
      chk_b("mid_rst_dmem_read", dmem_read, 1'b0);
      chk_b("mid_rst_resp_valid", resp_valid, 1'b0);
      chk_b("mid_rst_req_ready", req_ready, 1'b1);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk_i("mid_rst_no_resp", resp_count - rc0, 0);
      chk_b("mid_rst_ready_after", req_ready, 1'b1);
      ready_delay = 0;
      issue(1'b0, 3'b011, 64'h20, 64'h0, 5'd29, model_load(mem[4], 3'd0, 3'b011), 2'b00, 1'b0);
      wait_resp("post_rst_load_done");

      chk_b("rw_never_overlap", rw_overlap, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
